// File: rtl/r5p_bus_pkg.sv
// rtl/r5p_bus_pkg.sv - shared types and decode helpers for the bus decoder
package r5p_bus_pkg;

   // Widest supported port count and address; narrower instances zero-extend.
   localparam int BN_MAX = 16;
   localparam int AW_MAX = 64;

   // One response-pipeline slot: which port answers, or the default responder.
   typedef struct packed {
      logic [BN_MAX-1:0] sel;
      logic              miss;
      logic              wen;
   } stage_t;

   // Region hit: every masked address bit equals the match value.
   function automatic logic dec_hit(input logic [AW_MAX-1:0] adr,
                                    input logic [AW_MAX-1:0] mask,
                                    input logic [AW_MAX-1:0] match);
      return ((adr ^ match) & mask) == '0;
   endfunction

   // Keep only the lowest set bit (fixed priority, index 0 highest).
   function automatic logic [BN_MAX-1:0] onehot_lsb(input logic [BN_MAX-1:0] vec);
      return vec & (~vec + BN_MAX'(1));
   endfunction

endpackage

// File: rtl/r5p_bus_dec_pipe_if.sv
// rtl/r5p_bus_dec_pipe_if.sv - subordinate and manager-side bus bundle
interface r5p_bus_dec_pipe_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int BN = 2
);
   logic                 s_vld;
   logic                 s_wen;
   logic [DW/8-1:0]      s_ben;
   logic [AW-1:0]        s_adr;
   logic [DW-1:0]        s_wdt;
   logic [DW-1:0]        s_rdt;
   logic                 s_rdy;
   logic                 s_err;
   logic [BN-1:0]        m_vld;
   logic [BN-1:0]        m_wen;
   logic [BN*DW/8-1:0]   m_ben;
   logic [BN*AW-1:0]     m_adr;
   logic [BN*DW-1:0]     m_wdt;
   logic [BN*DW-1:0]     m_rdt;
   logic [BN-1:0]        m_rdy;

   // Environment side: drives requests and peripheral responses.
   modport master (
      output s_vld, s_wen, s_ben, s_adr, s_wdt,
      input  s_rdt, s_rdy, s_err,
      input  m_vld, m_wen, m_ben, m_adr, m_wdt,
      output m_rdt, m_rdy
   );

   // Decoder side.
   modport slave (
      input  s_vld, s_wen, s_ben, s_adr, s_wdt,
      output s_rdt, s_rdy, s_err,
      output m_vld, m_wen, m_ben, m_adr, m_wdt,
      input  m_rdt, m_rdy
   );
endinterface

// File: rtl/r5p_bus_err_mon.sv
// rtl/r5p_bus_err_mon.sv - unmapped-access counter, sticky flag and first address
module r5p_bus_err_mon #(
   parameter int AW  = 32,
   parameter int ECW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           evt,
   input  logic [AW-1:0]  adr,
   input  logic           clr,
   output logic           err_vld,
   output logic [AW-1:0]  err_adr,
   output logic [ECW-1:0] err_cnt
);
   logic           vld_q, vld_d;
   logic [AW-1:0]  adr_q, adr_d;
   logic [ECW-1:0] cnt_q, cnt_d;

   // Next state: a clear wipes history, but an event in the same cycle is kept.
   always_comb begin
      vld_d = vld_q;
      adr_d = adr_q;
      cnt_d = cnt_q;
      if (clr) begin
         vld_d = 1'b0;
         adr_d = '0;
         cnt_d = '0;
      end
      if (evt) begin
         if (clr)
            cnt_d = ECW'(1);
         else if (cnt_q != '1)
            cnt_d = cnt_q + ECW'(1);
         if (clr || !vld_q) begin
            adr_d = adr;
            vld_d = 1'b1;
         end
      end
   end

   // Error status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         adr_q <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         adr_q <= adr_d;
         cnt_q <= cnt_d;
      end
   end

   assign err_vld = vld_q;
   assign err_adr = adr_q;
   assign err_cnt = cnt_q;
endmodule

// File: rtl/r5p_bus_dec_pipe.sv
// rtl/r5p_bus_dec_pipe.sv - mask/match address decoder with fixed-latency response pipeline
module r5p_bus_dec_pipe
   import r5p_bus_pkg::*;
#(
   parameter int                     AW      = 32,
   parameter int                     DW      = 32,
   parameter int                     BN      = 2,
   parameter int                     RL      = 1,
   parameter logic [BN-1:0][AW-1:0]  AM      = '0,
   parameter logic [BN-1:0][AW-1:0]  AS      = '0,
   parameter logic [DW-1:0]          DEF_RDT = '0,
   parameter int                     ECW     = 8
) (
   input  logic                clk,
   input  logic                rst,
   r5p_bus_dec_pipe_if.slave   bus,
   input  logic                err_clr,
   output logic                err_vld,
   output logic [AW-1:0]       err_adr,
   output logic [ECW-1:0]      err_cnt
);
   logic [BN-1:0] hit;
   logic [BN-1:0] sel;
   logic          miss;
   logic          xfer;
   stage_t        cur;
   stage_t        last;
   logic [DW-1:0] rdt_arr [BN_MAX];

   // Decode: test every region, lowest index wins on overlap.
   always_comb begin
      hit = '0;
      for (int i = 0; i < BN; i++)
         hit[i] = dec_hit(AW_MAX'(bus.s_adr), AW_MAX'(AM[i]), AW_MAX'(AS[i]));
      sel  = BN'(onehot_lsb(BN_MAX'(hit)));
      miss = ~|hit;
   end

   // Forward path and handshake; the default responder never stalls.
   always_comb begin
      bus.s_rdy = (|(sel & bus.m_rdy)) | miss;
      xfer      = bus.s_vld & bus.s_rdy;
      bus.m_vld = rst ? '0 : ({BN{bus.s_vld}} & sel);
      bus.m_wen = {BN{bus.s_wen}} & sel;
      bus.m_ben = {BN{bus.s_ben}};
      bus.m_adr = {BN{bus.s_adr}};
      bus.m_wdt = {BN{bus.s_wdt}};
   end

   // Slot describing this cycle's transfer; empty when nothing transfers.
   always_comb begin
      cur = '0;
      if (xfer) begin
         cur.sel  = BN_MAX'(sel);
         cur.miss = miss;
         cur.wen  = bus.s_wen;
      end
   end

   if (RL == 0) begin : g_nopipe
      assign last = cur;
   end else begin : g_pipe
      stage_t [RL-1:0] p_q;
      stage_t [RL-1:0] p_d;

      // Shift: a new slot enters stage 0, the response is taken from stage RL-1.
      always_comb begin
         p_d    = p_q;
         p_d[0] = cur;
         for (int k = 1; k < RL; k++)
            p_d[k] = p_q[k-1];
      end

      // Pipeline registers; reset drops every in-flight response.
      always_ff @(posedge clk) begin
         if (rst)
            p_q <= '0;
         else
            p_q <= p_d;
      end

      assign last = p_q[RL-1];
   end

   // Unused port slots read as zero so the response mux can scan every bit.
   for (genvar i = 0; i < BN_MAX; i++) begin : g_rdt
      if (i < BN) begin : g_port
         assign rdt_arr[i] = bus.m_rdt[i*DW +: DW];
      end else begin : g_none
         assign rdt_arr[i] = '0;
      end
   end

   // Response mux: selected port data, or default data for unmapped reads.
   always_comb begin
      bus.s_rdt = '0;
      for (int i = 0; i < BN_MAX; i++)
         if (last.sel[i])
            bus.s_rdt = bus.s_rdt | rdt_arr[i];
      if (last.miss && !last.wen)
         bus.s_rdt = bus.s_rdt | DEF_RDT;
      bus.s_err = last.miss;
   end

   r5p_bus_err_mon #(
      .AW  (AW),
      .ECW (ECW)
   ) u_err_mon (
      .clk     (clk),
      .rst     (rst),
      .evt     (xfer & miss),
      .adr     (bus.s_adr),
      .clr     (err_clr),
      .err_vld (err_vld),
      .err_adr (err_adr),
      .err_cnt (err_cnt)
   );
endmodule

// File: tb/tb_r5p_bus_dec_pipe.sv
// tb/tb_r5p_bus_dec_pipe.sv - randomized and directed bench for r5p_bus_dec_pipe
module tb_r5p_bus_dec_pipe;

   localparam logic [31:0] DEF = 32'hDEAD_BEEF;
   // Three instances: d0 RL=1 ECW=2, d1 RL=3 ECW=8 overlapping, d2 RL=0 ECW=4 overlapping.
   localparam logic [2:0][1:0][31:0] AM_T = {
      {32'hF000_0000, 32'hFF00_0000},
      {32'hE000_0000, 32'hF000_0000},
      {32'hF000_0000, 32'hF000_0000}};
   localparam logic [2:0][1:0][31:0] AS_T = {
      {32'h0000_0000, 32'h0000_0000},
      {32'h0000_0000, 32'h1000_0000},
      {32'h2000_0000, 32'h0000_0000}};
   localparam int RLS  [3] = '{1, 3, 0};
   localparam int CMAX [3] = '{3, 255, 15};

   logic clk;
   logic        rst     [3];
   logic        s_vld   [3];
   logic        s_wen   [3];
   logic [3:0]  s_ben   [3];
   logic [31:0] s_adr   [3];
   logic [31:0] s_wdt   [3];
   logic [1:0]  m_rdy   [3];
   logic [63:0] m_rdt   [3];
   logic        err_clr [3];

   wire [31:0] s_rdt_o   [3];
   wire        s_rdy_o   [3];
   wire        s_err_o   [3];
   wire [1:0]  m_vld_o   [3];
   wire [1:0]  m_wen_o   [3];
   wire [7:0]  m_ben_o   [3];
   wire [63:0] m_adr_o   [3];
   wire [63:0] m_wdt_o   [3];
   wire        err_vld_o [3];
   wire [31:0] err_adr_o [3];
   wire [7:0]  err_cnt_o [3];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar d = 0; d < 3; d++) begin : g_dut
      localparam int RLD  = (d == 0) ? 1 : (d == 1) ? 3 : 0;
      localparam int ECWD = (d == 0) ? 2 : (d == 1) ? 8 : 4;
      logic [ECWD-1:0] ecnt;

      r5p_bus_dec_pipe_if #(.AW(32), .DW(32), .BN(2)) bus ();

      assign bus.s_vld = s_vld[d];
      assign bus.s_wen = s_wen[d];
      assign bus.s_ben = s_ben[d];
      assign bus.s_adr = s_adr[d];
      assign bus.s_wdt = s_wdt[d];
      assign bus.m_rdy = m_rdy[d];
      assign bus.m_rdt = m_rdt[d];
      assign s_rdt_o[d] = bus.s_rdt;
      assign s_rdy_o[d] = bus.s_rdy;
      assign s_err_o[d] = bus.s_err;
      assign m_vld_o[d] = bus.m_vld;
      assign m_wen_o[d] = bus.m_wen;
      assign m_ben_o[d] = bus.m_ben;
      assign m_adr_o[d] = bus.m_adr;
      assign m_wdt_o[d] = bus.m_wdt;
      assign err_cnt_o[d] = 8'(ecnt);

      r5p_bus_dec_pipe #(
         .AW(32), .DW(32), .BN(2), .RL(RLD),
         .AM(AM_T[d]), .AS(AS_T[d]), .DEF_RDT(DEF), .ECW(ECWD)
      ) u_dut (
         .clk     (clk),
         .rst     (rst[d]),
         .bus     (bus.slave),
         .err_clr (err_clr[d]),
         .err_vld (err_vld_o[d]),
         .err_adr (err_adr_o[d]),
         .err_cnt (ecnt)
      );
   end

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[d%0d] t=%0t got %h expected %h", nm, d, $time, act, exp);
      end
   endtask

   // Reference: which port answers an address (-1 = default responder).
   function automatic int dec(input int d, input logic [31:0] a);
      for (int i = 0; i < 2; i++)
         if ((a & AM_T[d][i]) == (AS_T[d][i] & AM_T[d][i])) return i;
      return -1;
   endfunction

   typedef struct { bit v; int port; bit wen; } ev_t;
   ev_t         pl   [3][4];
   bit          ok   [3];
   bit          mvld [3];
   logic [31:0] madr [3];
   int          mcnt [3];

   // Compare every instance against the reference on each falling edge, then advance it.
   always @(negedge clk) begin : cmp
      int p;
      bit rdy, xf;
      ev_t cur, last;
      logic [31:0] er;
      logic [1:0] ev, ew;
      for (int d = 0; d < 3; d++) begin
         p = dec(d, s_adr[d]);
         rdy = (p < 0) ? 1'b1 : m_rdy[d][p];
         xf = s_vld[d] && rdy;
         cur.v = xf; cur.port = p; cur.wen = s_wen[d];
         last = (RLS[d] == 0) ? cur : pl[d][RLS[d]-1];
         if (!last.v) er = '0;
         else if (last.port >= 0) er = m_rdt[d][last.port*32 +: 32];
         else er = last.wen ? 32'h0 : DEF;
         ev = (!rst[d] && s_vld[d] && p >= 0) ? 2'(1 << p) : 2'b00;
         ew = (s_wen[d] && p >= 0) ? 2'(1 << p) : 2'b00;
         if (ok[d]) begin
            chk("s_rdt", d, s_rdt_o[d], er);
            chk("s_err", d, s_err_o[d], last.v && last.port < 0);
            chk("s_rdy", d, s_rdy_o[d], rdy);
            chk("m_vld", d, m_vld_o[d], ev);
            chk("m_wen", d, m_wen_o[d], ew);
            chk("m_ben", d, m_ben_o[d], {s_ben[d], s_ben[d]});
            chk("m_adr", d, m_adr_o[d], {s_adr[d], s_adr[d]});
            chk("m_wdt", d, m_wdt_o[d], {s_wdt[d], s_wdt[d]});
            chk("err_vld", d, err_vld_o[d], mvld[d]);
            chk("err_adr", d, err_adr_o[d], madr[d]);
            chk("err_cnt", d, err_cnt_o[d], mcnt[d]);
         end
         if (rst[d]) begin
            for (int k = 0; k < 4; k++) pl[d][k].v = 0;
            mvld[d] = 0; madr[d] = '0; mcnt[d] = 0; ok[d] = 1;
         end else begin
            for (int k = 3; k > 0; k--) pl[d][k] = pl[d][k-1];
            pl[d][0] = cur;
            if (xf && p < 0) begin
               if (err_clr[d]) begin
                  mcnt[d] = 1; madr[d] = s_adr[d]; mvld[d] = 1;
               end else begin
                  if (mcnt[d] < CMAX[d]) mcnt[d]++;
                  if (!mvld[d]) begin madr[d] = s_adr[d]; mvld[d] = 1; end
               end
            end else if (err_clr[d]) begin
               mcnt[d] = 0; madr[d] = '0; mvld[d] = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle(input int d);
      s_vld[d] = 0; s_wen[d] = 0; s_ben[d] = 4'hF; s_adr[d] = '0; s_wdt[d] = '0;
      m_rdy[d] = 2'b11; err_clr[d] = 0; rst[d] = 0;
   endtask

   function automatic logic [31:0] radr();
      logic [31:0] a;
      a = $urandom;
      case ($urandom_range(0, 3))
         0: a[31:24] = 8'($urandom_range(0, 2));
         1: a[31:28] = 4'($urandom_range(0, 5));
         default: ;
      endcase
      return a;
   endfunction

   initial begin
      for (int d = 0; d < 3; d++) begin idle(d); rst[d] = 1; m_rdt[d] = '0; end
      tick(); tick();
      for (int d = 0; d < 3; d++) rst[d] = 0;
      at_neg();
      for (int d = 0; d < 3; d++) begin
         chk("rst_s_rdt", d, s_rdt_o[d], 0);
         chk("rst_s_err", d, s_err_o[d], 0);
         chk("rst_err_vld", d, err_vld_o[d], 0);
         chk("rst_err_cnt", d, err_cnt_o[d], 0);
         chk("rst_err_adr", d, err_adr_o[d], 0);
      end

      // back-to-back reads to two ports (RL=1)
      m_rdt[0] = {32'h2222, 32'h1111};
      tick(); s_vld[0] = 1; s_adr[0] = 32'h0000_0010; at_neg();
      chk("t1_m_vld0", 0, m_vld_o[0], 2'b01);
      chk("t1_s_rdy", 0, s_rdy_o[0], 1);
      tick(); s_adr[0] = 32'h2000_0004; at_neg();
      chk("t1_rdt0", 0, s_rdt_o[0], 32'h1111);
      chk("t1_err0", 0, s_err_o[0], 0);
      chk("t1_m_vld1", 0, m_vld_o[0], 2'b10);
      tick(); s_vld[0] = 0; at_neg();
      chk("t1_rdt1", 0, s_rdt_o[0], 32'h2222);

      // unmapped read
      tick(); s_vld[0] = 1; s_adr[0] = 32'h4000_0000; at_neg();
      chk("t2_s_rdy", 0, s_rdy_o[0], 1);
      chk("t2_m_vld", 0, m_vld_o[0], 0);
      tick(); s_vld[0] = 0; at_neg();
      chk("t2_rdt", 0, s_rdt_o[0], DEF);
      chk("t2_err", 0, s_err_o[0], 1);
      chk("t2_err_vld", 0, err_vld_o[0], 1);
      chk("t2_err_adr", 0, err_adr_o[0], 32'h4000_0000);
      chk("t2_err_cnt", 0, err_cnt_o[0], 1);
      tick(); err_clr[0] = 1; at_neg();
      tick(); err_clr[0] = 0; at_neg();
      chk("t2_clr_cnt", 0, err_cnt_o[0], 0);
      chk("t2_clr_vld", 0, err_vld_o[0], 0);

      // port0 stalls three cycles
      m_rdt[0][31:0] = 32'h3333;
      tick(); m_rdy[0] = 2'b10; s_vld[0] = 1; s_adr[0] = 32'h0000_0010; at_neg();
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin tick(); at_neg(); end
         chk("t3_stall_rdy", 0, s_rdy_o[0], 0);
         chk("t3_stall_rdt", 0, s_rdt_o[0], 0);
      end
      tick(); m_rdy[0] = 2'b11; at_neg();
      chk("t3_go_rdy", 0, s_rdy_o[0], 1);
      tick(); s_vld[0] = 0; at_neg();
      chk("t3_rdt", 0, s_rdt_o[0], 32'h3333);
      tick(); at_neg();
      chk("t3_single", 0, s_rdt_o[0], 0);

      // saturating counter with ECW=2, then clear coincident with a miss
      s_wen[0] = 1;
      for (int k = 0; k < 5; k++) begin
         tick(); s_vld[0] = 1; s_adr[0] = 32'h5000_0000 + 32'(k * 4); at_neg();
         if (k > 0) begin
            chk("t4_wr_rdt", 0, s_rdt_o[0], 0);
            chk("t4_wr_err", 0, s_err_o[0], 1);
         end
      end
      tick(); s_adr[0] = 32'h6000_0000; err_clr[0] = 1; at_neg();
      chk("t4_sat_cnt", 0, err_cnt_o[0], 3);
      chk("t4_first_adr", 0, err_adr_o[0], 32'h5000_0000);
      tick(); s_vld[0] = 0; s_wen[0] = 0; err_clr[0] = 0; at_neg();
      chk("t4_clr_cnt", 0, err_cnt_o[0], 1);
      chk("t4_clr_adr", 0, err_adr_o[0], 32'h6000_0000);
      chk("t4_clr_vld", 0, err_vld_o[0], 1);
      chk("t4_wr6_rdt", 0, s_rdt_o[0], 0);

      // RL=3, reset with responses in flight
      m_rdt[1] = {32'hBBBB, 32'hAAAA};
      tick(); s_vld[1] = 1; s_adr[1] = 32'h0000_0100; at_neg();
      tick(); s_adr[1] = 32'h1000_0000; at_neg();
      chk("t5_overlap", 1, m_vld_o[1], 2'b01);
      tick(); s_adr[1] = 32'h4000_0000; at_neg();
      tick(); s_vld[1] = 0; rst[1] = 1; at_neg();
      chk("t5_first_rdt", 1, s_rdt_o[1], 32'hBBBB);
      chk("t5_pre_cnt", 1, err_cnt_o[1], 1);
      tick(); rst[1] = 0; at_neg();
      chk("t5_post_cnt", 1, err_cnt_o[1], 0);
      for (int c = 0; c < 4; c++) begin
         chk("t5_post_rdt", 1, s_rdt_o[1], 0);
         chk("t5_post_err", 1, s_err_o[1], 0);
         tick(); at_neg();
      end

      // RL=0 with overlapping regions
      m_rdt[2] = {32'h8888, 32'h7777};
      tick(); s_vld[2] = 1; s_adr[2] = 32'h0000_0040; at_neg();
      chk("t6_m_vld", 2, m_vld_o[2], 2'b01);
      chk("t6_rdt0", 2, s_rdt_o[2], 32'h7777);
      chk("t6_err0", 2, s_err_o[2], 0);
      tick(); s_adr[2] = 32'h0100_0000; at_neg();
      chk("t6_rdt1", 2, s_rdt_o[2], 32'h8888);
      tick(); s_adr[2] = 32'h3000_0000; at_neg();
      chk("t6_def", 2, s_rdt_o[2], DEF);
      chk("t6_miss_err", 2, s_err_o[2], 1);
      tick(); s_vld[2] = 0; at_neg();
      chk("t6_idle", 2, s_rdt_o[2], 0);
      chk("t6_cnt", 2, err_cnt_o[2], 1);

      // randomized traffic, all instances
      for (int n = 0; n < 2000; n++) begin
         tick();
         for (int d = 0; d < 3; d++) begin
            s_vld[d]   = ($urandom_range(0, 3) != 0);
            s_wen[d]   = 1'($urandom);
            s_ben[d]   = 4'($urandom);
            s_adr[d]   = radr();
            s_wdt[d]   = $urandom;
            m_rdy[d]   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            m_rdt[d]   = {$urandom, $urandom};
            err_clr[d] = ($urandom_range(0, 19) == 0);
            rst[d]     = ($urandom_range(0, 99) == 0);
         end
      end
      tick();
      for (int d = 0; d < 3; d++) idle(d);
      repeat (5) tick();
      at_neg();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
